ring_mem_stop: RTL
==================

RING_MEM_STOP -- requirements
Module: ring_mem_stop

Interface
REQ-001 SHALL have one clock and reset: clock (in, 1, sole clock), then reset (in, 1, asynchronous, active-high).
REQ-002 SHALL take RingIn (in, 32), SlotTypeIn (in, 4) and SrcDestIn (in, 4): the ring slot arriving at this stop.
REQ-003 SHALL drive RingOut (out, 32), SlotTypeOut (out, 4) and SrcDestOut (out, 4): the ring slot leaving this stop, registered.
REQ-004 SHALL drive RDreturn (out, 32) and RDdest (out, 4): the read-data return ring, registered.
REQ-005 SHALL provide a command channel: mCmdValid (out, 1), mCmdReady (in, 1), mCmdWrite (out, 1), mCmdAddr (out, 28, line address).
REQ-006 SHALL provide a write-data channel: mWData (out, 32) and mWDataRd (in, 1, controller consumes one word per pulse).
REQ-007 SHALL provide a read-data channel: mRData (in, 32) and mRDataValid (in, 1, one beat per pulse, 8 beats per line).
REQ-008 SHALL drive overflow (out, 1): sticky error flag, cleared only by reset.

Function
REQ-009 Slot types SHALL be: Token=1, Address=2, WriteData=3, ReadData=4, Null=7.
REQ-010 Address slot decode SHALL be: RingIn[28]=1 means read, 0 means write; RingIn[29]=1 means I-fetch, ignored here; RingIn[27:0] is the line address; SrcDestIn is the requesting core.
REQ-011 Address and WriteData slots SHALL be consumed and forwarded as SlotTypeOut=Null, RingOut=0, SrcDestOut=0; all other slots SHALL be forwarded unchanged with 1-cycle latency.
REQ-012 WriteData slots SHALL fill an 8-word line buffer at index wcnt (3 bits, wraps 7->0); the write Address slot that follows SHALL mark the line full.
REQ-013 A read Address slot SHALL push {addr[27:0], core[3:0]} into a 4-entry read FIFO.
REQ-014 A read push with the FIFO full SHALL drop the request and set overflow.
REQ-015 A WriteData slot arriving while the line buffer is full SHALL be dropped and SHALL set overflow.
REQ-016 The controller FSM SHALL have states IDLE, WR_CMD, WR_DATA, RD_CMD, RD_DATA.
REQ-017 From IDLE the FSM SHALL go to WR_CMD when the line buffer is full (writes have priority), else to RD_CMD when the FIFO is non-empty.
REQ-018 WR_CMD SHALL assert mCmdValid with mCmdWrite=1 and go to WR_DATA on mCmdReady.
REQ-019 WR_DATA SHALL present buffer word rptr on mWData and advance rptr on each mWDataRd; after the 8th word it SHALL free the buffer and return to IDLE.
REQ-020 RD_CMD SHALL assert mCmdValid with mCmdWrite=0 at the FIFO head and go to RD_DATA on mCmdReady.
REQ-021 In RD_DATA, each mRDataValid SHALL produce RDreturn<=mRData and RDdest<=head core on the next cycle; on the 8th beat the FIFO SHALL pop and the FSM SHALL return to IDLE.
REQ-022 RDdest SHALL be 0 (no core) on every cycle without a beat; beats need not be contiguous.
REQ-023 A slot capture and an FSM drain of the same structure in the same cycle SHALL both take effect, giving correct full/empty accounting.

Reset
REQ-024 Reset SHALL clear the FSM to IDLE, all outputs to 0, SlotTypeOut to 0, the FIFO to empty, the line buffer to not-full, wcnt, rptr and beat counters to 0, and overflow to 0.
REQ-025 Reset mid-burst SHALL abandon the transaction; no partial RDreturn beat SHALL follow reset release.

Configuration
REQ-026 With RING_MEM_STATS_EN defined, the block SHALL add rdCount (out, 16) and wrCount (out, 16), each incremented per completed line and wrapping at 0xFFFF->0.
REQ-027 Without RING_MEM_STATS_EN, these ports and counters SHALL be absent.

Structure
REQ-028 Slot-type constants, FSM state encoding, and the read-request struct {addr, core} SHALL live in shared package ring_pkg.
REQ-029 The read FIFO SHALL be sub-module ring_req_fifo (parameter DEPTH=4, WIDTH=32, with full and empty outputs).

Verification
REQ-030 Ring traffic: Token RingIn=0x5 -> emerges unchanged one cycle later, with no command issued.
REQ-031 Clean miss: read Address 0x1000_0040 with SrcDestIn=3 -> mCmdAddr=0x0000040 with mCmdWrite=0; 8 beats return with RDdest=3; the input slot is output as Null.
REQ-032 Dirty miss: read address, then 8 WriteData 0xA0..0xA7, then write address 0x0ABCDEF -> write command issued first, mWData sequence 0xA0..0xA7, then the read command.
REQ-033 Stalled return: mRDataValid gapped 1-0-1, 8 beats total -> RDdest=core only on beat cycles and 0 otherwise.
REQ-034 FIFO overflow: 5 reads arrive with mCmdReady=0 -> 4 are queued, overflow=1, and the 5th never issues.
REQ-035 Reset asserted during beat 4 -> FSM to IDLE, RDdest=0, FIFO empty, overflow=0.

Source files
------------

// File: rtl/ring_pkg.sv
// Shared definitions for the ring memory stop: slot types, controller
// state encoding and the queued read-request record.
package ring_pkg;

    localparam logic [3:0] SLOT_TOKEN = 4'd1;
    localparam logic [3:0] SLOT_ADDR  = 4'd2;
    localparam logic [3:0] SLOT_WDATA = 4'd3;
    localparam logic [3:0] SLOT_RDATA = 4'd4;
    localparam logic [3:0] SLOT_NULL  = 4'd7;

    localparam int LINE_WORDS     = 8;
    localparam int REQ_FIFO_DEPTH = 4;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WR_CMD  = 3'd1,
        ST_WR_DATA = 3'd2,
        ST_RD_CMD  = 3'd3,
        ST_RD_DATA = 3'd4
    } ring_state_e;

    typedef struct packed {
        logic [27:0] addr;
        logic [3:0]  core;
    } rd_req_t;

endpackage

// File: rtl/ring_mem_stop_if.sv
// Memory-controller side of the ring stop: command, write-data and read-data channels.
// Handshake: a command transfers on a cycle where mCmdValid && mCmdReady; each mWDataRd
// pulse consumes the word on mWData; each mRDataValid pulse delivers one beat on mRData.
interface ring_mem_if;
    logic        mCmdValid;
    logic        mCmdReady;
    logic        mCmdWrite;
    logic [27:0] mCmdAddr;
    logic [31:0] mWData;
    logic        mWDataRd;
    logic [31:0] mRData;
    logic        mRDataValid;

    modport master (
        output mCmdValid, mCmdWrite, mCmdAddr, mWData,
        input  mCmdReady, mWDataRd, mRData, mRDataValid
    );

    modport slave (
        input  mCmdValid, mCmdWrite, mCmdAddr, mWData,
        output mCmdReady, mWDataRd, mRData, mRDataValid
    );
endinterface

// File: rtl/ring_req_fifo.sv
// Small synchronous FIFO for queued read requests. A push while full is
// accepted only if a pop happens in the same cycle.
module ring_req_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wptr_q, rptr_q;
    logic [AW:0]      count_q;
    logic             do_push, do_pop;

    assign full    = (count_q == (AW+1)'(DEPTH));
    assign empty   = (count_q == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = mem_q[rptr_q];

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wptr_q] <= din;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (do_push) wptr_q <= (wptr_q == AW'(DEPTH-1)) ? '0 : wptr_q + 1'b1;
            if (do_pop)  rptr_q <= (rptr_q == AW'(DEPTH-1)) ? '0 : rptr_q + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end
endmodule

// File: rtl/ring_mem_stop.sv
// Ring stop in front of a memory controller: absorbs address/write-data slots, buffers one
// write line and queues reads. Optional line counters under `ifdef RING_MEM_STATS_EN.
module ring_mem_stop
    import ring_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] RingIn,
    input  logic [3:0]  SlotTypeIn,
    input  logic [3:0]  SrcDestIn,
    output logic [31:0] RingOut,
    output logic [3:0]  SlotTypeOut,
    output logic [3:0]  SrcDestOut,
    output logic [31:0] RDreturn,
    output logic [3:0]  RDdest,
    output logic        overflow,
    ring_mem_if.master  mem,
    output ring_state_e dbg_state_o
`ifdef RING_MEM_STATS_EN
    ,
    output logic [15:0] rdCount,
    output logic [15:0] wrCount
`endif
);
    ring_state_e state_q, state_d;
    logic [31:0] ring_q, rdret_q, rdret_d;
    logic [3:0]  slot_q, sd_q, rddest_q, rddest_d;
    logic        ovf_q;
    logic [2:0]  rptr_q, rptr_d, beat_q, beat_d, wcnt_q;
    logic        line_full_q;
    logic [27:0] wr_addr_q;
    logic [31:0] line_buf_q [LINE_WORDS];

    logic    is_addr, is_wdata, is_rd_addr, is_wr_addr, wd_accept;
    logic    fifo_pop, fifo_full, fifo_empty, line_free;
    rd_req_t push_req, head_req;

    assign is_addr    = (SlotTypeIn == SLOT_ADDR);
    assign is_wdata   = (SlotTypeIn == SLOT_WDATA);
    assign is_rd_addr = is_addr && RingIn[28];
    assign is_wr_addr = is_addr && !RingIn[28];
    // A word arriving on the cycle the buffer drains lands in the freshly freed line.
    assign wd_accept  = is_wdata && (!line_full_q || line_free);
    assign push_req   = '{addr: RingIn[27:0], core: SrcDestIn};

    ring_req_fifo #(
        .DEPTH (REQ_FIFO_DEPTH),
        .WIDTH ($bits(rd_req_t))
    ) u_req_fifo (
        .clk   (clock),
        .rst   (reset),
        .push  (is_rd_addr),
        .din   (push_req),
        .pop   (fifo_pop),
        .dout  (head_req),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_comb begin
        state_d       = state_q;
        rptr_d        = rptr_q;
        beat_d        = beat_q;
        rdret_d       = '0;
        rddest_d      = '0;
        fifo_pop      = 1'b0;
        line_free     = 1'b0;
        mem.mCmdValid = 1'b0;
        mem.mCmdWrite = 1'b0;
        mem.mCmdAddr  = '0;
        mem.mWData    = '0;
        case (state_q)
            ST_IDLE: begin
                if (line_full_q)      state_d = ST_WR_CMD;
                else if (!fifo_empty) state_d = ST_RD_CMD;
            end
            ST_WR_CMD: begin
                mem.mCmdValid = 1'b1;
                mem.mCmdWrite = 1'b1;
                mem.mCmdAddr  = wr_addr_q;
                if (mem.mCmdReady) state_d = ST_WR_DATA;
            end
            ST_WR_DATA: begin
                mem.mWData = line_buf_q[rptr_q];
                if (mem.mWDataRd) begin
                    rptr_d = rptr_q + 3'd1;
                    if (rptr_q == 3'd7) begin
                        line_free = 1'b1;
                        state_d   = ST_IDLE;
                    end
                end
            end
            ST_RD_CMD: begin
                mem.mCmdValid = 1'b1;
                mem.mCmdAddr  = head_req.addr;
                if (mem.mCmdReady) state_d = ST_RD_DATA;
            end
            ST_RD_DATA: begin
                if (mem.mRDataValid) begin
                    rdret_d  = mem.mRData;
                    rddest_d = head_req.core;
                    beat_d   = beat_q + 3'd1;
                    if (beat_q == 3'd7) begin
                        fifo_pop = 1'b1;
                        state_d  = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (wd_accept) line_buf_q[wcnt_q] <= RingIn;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            ring_q      <= '0;
            slot_q      <= '0;
            sd_q        <= '0;
            rdret_q     <= '0;
            rddest_q    <= '0;
            ovf_q       <= 1'b0;
            rptr_q      <= '0;
            beat_q      <= '0;
            wcnt_q      <= '0;
            line_full_q <= 1'b0;
            wr_addr_q   <= '0;
        end else begin
            state_q  <= state_d;
            rptr_q   <= rptr_d;
            beat_q   <= beat_d;
            rdret_q  <= rdret_d;
            rddest_q <= rddest_d;
            if (is_addr || is_wdata) begin
                slot_q <= SLOT_NULL;
                ring_q <= '0;
                sd_q   <= '0;
            end else begin
                slot_q <= SlotTypeIn;
                ring_q <= RingIn;
                sd_q   <= SrcDestIn;
            end
            if (wd_accept) wcnt_q <= wcnt_q + 3'd1;
            if (is_wr_addr) begin
                wr_addr_q   <= RingIn[27:0];
                line_full_q <= 1'b1;
            end else if (line_free) begin
                line_full_q <= 1'b0;
            end
            if ((is_wdata && !wd_accept) || (is_rd_addr && fifo_full && !fifo_pop))
                ovf_q <= 1'b1;
        end
    end

`ifdef RING_MEM_STATS_EN
    logic [15:0] rd_count_q, wr_count_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rd_count_q <= '0;
            wr_count_q <= '0;
        end else begin
            if (fifo_pop)  rd_count_q <= rd_count_q + 16'd1;
            if (line_free) wr_count_q <= wr_count_q + 16'd1;
        end
    end

    assign rdCount = rd_count_q;
    assign wrCount = wr_count_q;
`endif

    assign RingOut     = ring_q;
    assign SlotTypeOut = slot_q;
    assign SrcDestOut  = sd_q;
    assign RDreturn    = rdret_q;
    assign RDdest      = rddest_q;
    assign overflow    = ovf_q;
    assign dbg_state_o = state_q;
endmodule
